// File: rtl/spu_pkg.sv
// Shared SPU types: register address/quadword typedefs and the writeback bus
// that every execution unit drives into the register file.
package spu_pkg;

   localparam int NUM_REGS = 128;
   localparam int DATA_W   = 128;
   localparam int ADDR_W   = 7;

   typedef logic [0:ADDR_W-1] reg_addr_t;
   typedef logic [0:DATA_W-1] quad_t;

   typedef struct packed {
      quad_t     rt_wb;
      reg_addr_t rt_addr_wb;
      logic      reg_write_wb;
   } wb_bus_t;

   function automatic logic wb_hit(input wb_bus_t wb, input reg_addr_t addr);
      return wb.reg_write_wb && (wb.rt_addr_wb == addr);
   endfunction

endpackage

// File: rtl/spu_rf_read_port.sv
// One registered read port of the SPU register file.
// With SPU_RF_WB_BYPASS_EN defined, same-cycle writeback data is forwarded.
module spu_rf_read_port
   import spu_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  reg_addr_t addr,
   input  quad_t     regs [NUM_REGS],
   input  wb_bus_t   wb_even,
   input  wb_bus_t   wb_odd,
   output quad_t     data
);

   quad_t rd_val;

`ifdef SPU_RF_WB_BYPASS_EN
   // Odd pipe is the later-issued instruction, so its data wins a double hit.
   always_comb begin
      rd_val = regs[addr];
      if (wb_hit(wb_odd, addr))
         rd_val = wb_odd.rt_wb;
      else if (wb_hit(wb_even, addr))
         rd_val = wb_even.rt_wb;
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_even, wb_odd};

   always_comb begin
      rd_val = regs[addr];
   end
`endif

   always_ff @(posedge clk) begin
      if (reset)
         data <= '0;
      else
         data <= rd_val;
   end

endmodule

// File: rtl/spu_reg_file.sv
// 128 x 128-bit SPU register file: three registered read ports, even/odd
// writeback ports. Optional same-cycle bypass via SPU_RF_WB_BYPASS_EN.
module spu_reg_file
   import spu_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  reg_addr_t ra_addr,
   input  reg_addr_t rb_addr,
   input  reg_addr_t rc_addr,
   output quad_t     ra,
   output quad_t     rb,
   output quad_t     rc,
   input  quad_t     rt_wb_even,
   input  reg_addr_t rt_addr_wb_even,
   input  logic      reg_write_wb_even,
   input  quad_t     rt_wb_odd,
   input  reg_addr_t rt_addr_wb_odd,
   input  logic      reg_write_wb_odd,
   output logic      write_conflict
);

   quad_t   regs [NUM_REGS];
   wb_bus_t wb_even;
   wb_bus_t wb_odd;

   assign wb_even = '{rt_wb: rt_wb_even, rt_addr_wb: rt_addr_wb_even,
                      reg_write_wb: reg_write_wb_even};
   assign wb_odd  = '{rt_wb: rt_wb_odd, rt_addr_wb: rt_addr_wb_odd,
                      reg_write_wb: reg_write_wb_odd};

   // Odd write is issued after even so it lands last on an address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else begin
         if (wb_even.reg_write_wb)
            regs[wb_even.rt_addr_wb] <= wb_even.rt_wb;
         if (wb_odd.reg_write_wb)
            regs[wb_odd.rt_addr_wb] <= wb_odd.rt_wb;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         write_conflict <= 1'b0;
      else
         write_conflict <= wb_even.reg_write_wb && wb_hit(wb_odd, wb_even.rt_addr_wb);
   end

   spu_rf_read_port u_port_a (
      .clk     (clk),
      .reset   (reset),
      .addr    (ra_addr),
      .regs    (regs),
      .wb_even (wb_even),
      .wb_odd  (wb_odd),
      .data    (ra)
   );

   spu_rf_read_port u_port_b (
      .clk     (clk),
      .reset   (reset),
      .addr    (rb_addr),
      .regs    (regs),
      .wb_even (wb_even),
      .wb_odd  (wb_odd),
      .data    (rb)
   );

   spu_rf_read_port u_port_c (
      .clk     (clk),
      .reset   (reset),
      .addr    (rc_addr),
      .regs    (regs),
      .wb_even (wb_even),
      .wb_odd  (wb_odd),
      .data    (rc)
   );

endmodule
